// File: rtl/extend_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// extend_rr_arbiter_if
//   Bundles the requester-side and consumer-side handshakes of the shared
//   sign/zero-extension unit. The signal suffixes (_i/_o) are written from the
//   arbiter's point of view, so the slave modport is the arbiter itself.
//
//   Requester side (NREQ lanes, packed):
//     req_valid_i  [NREQ-1:0]     request valid per requester
//     req_ready_o  [NREQ-1:0]     one-hot (or zero) accept
//     req_data_i   [16*NREQ-1:0]  requester k data at [16k+15:16k]
//     req_mode_i   [2*NREQ-1:0]   requester k mode at [2k+1:2k]
//   Consumer side:
//     resp_valid_o                result valid
//     resp_ready_i                consumer accepts result
//     resp_data_o  [31:0]         extended result
//     resp_id_o    [IDW-1:0]      index of the producing requester
//   Status:
//     busy_o                      mirrors resp_valid_o
//     done_cnt_o   [15:0]         completed responses, wrapping
// -----------------------------------------------------------------------------
interface extend_rr_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]    req_valid_i;
  logic [NREQ-1:0]    req_ready_o;
  logic [16*NREQ-1:0] req_data_i;
  logic [2*NREQ-1:0]  req_mode_i;
  logic               resp_valid_o;
  logic               resp_ready_i;
  logic [31:0]        resp_data_o;
  logic [IDW-1:0]     resp_id_o;
  logic               busy_o;
  logic [15:0]        done_cnt_o;

  // Arbiter side.
  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  req_mode_i,
    input  resp_ready_i,
    output req_ready_o,
    output resp_valid_o,
    output resp_data_o,
    output resp_id_o,
    output busy_o,
    output done_cnt_o
  );

  // Requesters plus consumer, as seen from outside the arbiter.
  modport master (
    output req_valid_i,
    output req_data_i,
    output req_mode_i,
    output resp_ready_i,
    input  req_ready_o,
    input  resp_valid_o,
    input  resp_data_o,
    input  resp_id_o,
    input  busy_o,
    input  done_cnt_o
  );

endinterface

// File: rtl/extend_rr_arbiter.sv
// -----------------------------------------------------------------------------
// extend_rr_arbiter
//   One registered 8/16 -> 32 bit sign/zero-extension datapath shared by NREQ
//   requesters (load unit, immediate decoder, debug port, ...). Requesters are
//   served round-robin; the result sits in a one-deep output register with a
//   valid/ready handshake toward the register-write path.
//
//   Ports:
//     clk_i     clock, all state on the rising edge
//     areset_i  asynchronous active-high reset; also forces req_ready_o low
//     bus       extend_rr_arbiter_if.slave (request lanes, response, status)
//
//   Mode encoding per request: 00 zext byte, 01 sext byte,
//                              10 zext half, 11 sext half.
//   A new request is accepted whenever the output register is empty or is
//   being drained in the same cycle, giving one result per cycle back-to-back.
// -----------------------------------------------------------------------------
module extend_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input logic                clk_i,
  input logic                areset_i,
  extend_rr_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Sign/zero extension of a 16-bit lane; byte modes ignore d[15:8].
  function automatic logic [31:0] f_extend(input logic [15:0] d,
                                           input logic [1:0]  mode);
    logic [31:0] res;
    case (mode)
      2'b00:   res = {24'h000000, d[7:0]};
      2'b01:   res = {{24{d[7]}}, d[7:0]};
      2'b10:   res = {16'h0000, d[15:0]};
      2'b11:   res = {{16{d[15]}}, d[15:0]};
      default: res = 32'h0000_0000;
    endcase
    return res;
  endfunction

  // (base + off) modulo NREQ. Both operands are below NREQ, so a single
  // conditional subtraction is enough, including for non-power-of-two NREQ.
  function automatic logic [IDW-1:0] f_wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned    off);
    logic [IDW:0] sum;
    sum = {1'b0, base} + off[IDW:0];
    if (sum >= (IDW+1)'(NREQ)) begin
      sum = sum - (IDW+1)'(NREQ);
    end else begin
      sum = sum;
    end
    return sum[IDW-1:0];
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t         r_state;
  logic           r_resp_valid;
  logic [31:0]    r_resp_data;
  logic [IDW-1:0] r_resp_id;
  logic [15:0]    r_done_cnt;
  logic [IDW-1:0] r_ptr;        // highest-priority requester for next grant

  // ---------------------------------------------------------------------------
  // Combinational arbitration
  // ---------------------------------------------------------------------------
  logic            w_can_accept;
  logic            w_found;
  logic [IDW-1:0]  w_grant_idx;
  logic            w_grant;
  logic [NREQ-1:0] w_grant_oh;
  logic [15:0]     w_sel_data;
  logic [1:0]      w_sel_mode;
  logic [31:0]     w_ext_data;
  logic [IDW-1:0]  w_ptr_next;
  logic            w_complete;

  // The slot frees up either when empty or when the consumer drains it now.
  assign w_can_accept = (r_state == ST_EMPTY) || bus.resp_ready_i;
  assign w_complete   = r_resp_valid && bus.resp_ready_i;

  // Round-robin scan starting at r_ptr; first valid requester wins.
  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && bus.req_valid_i[f_wrap_add(r_ptr, k)]) begin
        w_found     = 1'b1;
        w_grant_idx = f_wrap_add(r_ptr, k);
      end else begin
        w_found     = w_found;
        w_grant_idx = w_grant_idx;
      end
    end
  end

  // Reset must silence every ready line even though the scan itself is
  // purely combinational.
  assign w_grant = w_can_accept && w_found && !areset_i;

  // One-hot accept toward the granted requester, zero otherwise.
  always_comb begin
    if (w_grant) begin
      w_grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_grant_idx;
    end else begin
      w_grant_oh = '0;
    end
  end

  // Operand mux and extension of the granted lane.
  always_comb begin
    w_sel_data = bus.req_data_i[16*int'(w_grant_idx) +: 16];
    w_sel_mode = bus.req_mode_i[2*int'(w_grant_idx) +: 2];
    w_ext_data = f_extend(w_sel_data, w_sel_mode);
  end

  // Pointer moves one past the winner, wrapping at NREQ-1.
  always_comb begin
    if (w_grant_idx == IDW'(NREQ-1)) begin
      w_ptr_next = '0;
    end else begin
      w_ptr_next = w_grant_idx + IDW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register FSM, result register, pointer and completion counter
  // ---------------------------------------------------------------------------
  // Single state machine owning every register of the block.
  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      r_state      <= ST_EMPTY;
      r_resp_valid <= 1'b0;
      r_resp_data  <= 32'h0000_0000;
      r_resp_id    <= '0;
      r_done_cnt   <= 16'h0000;
      r_ptr        <= '0;
    end else begin
      // Counts drains in every case, including back-to-back reloads.
      if (w_complete) begin
        r_done_cnt <= r_done_cnt + 16'h0001;
      end else begin
        r_done_cnt <= r_done_cnt;
      end

      case (r_state)
        ST_EMPTY: begin
          if (w_grant) begin
            r_state      <= ST_FULL;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_ext_data;
            r_resp_id    <= w_grant_idx;
            r_ptr        <= w_ptr_next;
          end else begin
            r_state      <= ST_EMPTY;
            r_resp_valid <= 1'b0;
          end
        end

        ST_FULL: begin
          if (bus.resp_ready_i && w_grant) begin
            // Drain and reload in the same cycle.
            r_state      <= ST_FULL;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_ext_data;
            r_resp_id    <= w_grant_idx;
            r_ptr        <= w_ptr_next;
          end else if (bus.resp_ready_i) begin
            // Data/id keep their last values after the drain.
            r_state      <= ST_EMPTY;
            r_resp_valid <= 1'b0;
          end else begin
            r_state      <= ST_FULL;
            r_resp_valid <= 1'b1;
          end
        end

        default: begin
          r_state      <= ST_EMPTY;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.req_ready_o  = w_grant_oh;
  assign bus.resp_valid_o = r_resp_valid;
  assign bus.resp_data_o  = r_resp_data;
  assign bus.resp_id_o    = r_resp_id;
  assign bus.busy_o       = r_resp_valid;
  assign bus.done_cnt_o   = r_done_cnt;

endmodule

// File: doc/extend_rr_arbiter.md
Name: extend_rr_arbiter

Overview:
- Shares one registered sign/zero-extension datapath (8- or 16-bit in, 32-bit out) between NREQ requesters.
- Each requester uses a valid/ready handshake and selects its extension mode per request.
- Round-robin arbitration; one-deep output register with a valid/ready handshake toward the consumer.
- Sits between requesting units (load unit, immediate decoder, debug port) and the register-write path.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, $clog2(NREQ), width of requester index

Ports:
clk_i  input  1  clock, all logic on rising edge
areset_i  input  1  asynchronous active-high reset
req_valid_i  input  NREQ  per-requester request valid
req_ready_o  output  NREQ  per-requester accept (one-hot or zero)
req_data_i  input  16*NREQ  requester k data at bits [16k+15:16k]
req_mode_i  input  2*NREQ  requester k mode at [2k+1:2k]: 00 zext byte, 01 sext byte, 10 zext half, 11 sext half
resp_valid_o  output  1  result valid
resp_ready_i  input  1  consumer accepts result
resp_data_o  output  32  extended result
resp_id_o  output  IDW  index of requester that produced resp_data_o
busy_o  output  1  equals resp_valid_o
done_cnt_o  output  16  count of completed responses (resp_valid_o && resp_ready_i), wraps 0xFFFF->0

Behaviour:
- Reset (async, while areset_i=1): resp_valid_o=0, resp_data_o=0, resp_id_o=0, done_cnt_o=0, RR pointer=0 (requester 0 highest priority). req_ready_o=0 is forced combinationally while areset_i=1.
- Reset asserted mid-transaction discards any held response; nothing is replayed after release.
- States:
  - EMPTY: resp_valid_o=0.
  - FULL: resp_valid_o=1; resp_data_o and resp_id_o stay stable until the handshake.
- can_accept = EMPTY || (FULL && resp_ready_i).
- Grant (combinational):
  - If can_accept and any req_valid_i, grant the first valid requester scanning ptr, ptr+1, ..., NREQ-1, 0, ... (modulo NREQ).
  - req_ready_o = onehot(grant), else 0. req_ready_o never depends on req_valid_i of the granted line alone: it is asserted only with that line's valid.
- Accept on a clock edge with a grant:
  - resp_data_o <= extend(data, mode); resp_id_o <= granted index; state FULL; ptr <= granted index + 1 (wrap NREQ-1 -> 0).
  - Latency: request accepted at edge N gives resp_valid_o=1 after edge N.
- Extension:
  - 00: {24'b0, d[7:0]}
  - 01: {{24{d[7]}}, d[7:0]}
  - 10: {16'b0, d[15:0]}
  - 11: {{16{d[15]}}, d[15:0]}
  - Unused upper data bits are ignored in byte modes.
- FULL && resp_ready_i with no grant: state EMPTY next edge; resp_data_o/resp_id_o keep their last values.
- FULL && resp_ready_i with a grant: stays FULL, new data loaded. Back-to-back throughput is 1 result per cycle.
- FULL && !resp_ready_i: hold everything, req_ready_o=0. Requesters must keep valid and data stable until they see ready; the block does not check this.
- done_cnt_o increments on every resp_valid_o && resp_ready_i edge, including the back-to-back case.
- ptr does not change when nothing is granted.

Test Plan:
- Reset, then single request:
  - Stimulus: areset_i=1 for 3 cycles then 0; req 2 valid, mode 01, data 0x0080.
  - Required: req_ready_o=4'b0100 for one cycle; next cycle resp_valid_o=1, resp_data_o=0xFFFFFF80, resp_id_o=2.
  - Consumer ready: done_cnt_o=1.
- All modes on requester 0 with data 0x8A85:
  - 00 -> 0x00000085; 01 -> 0xFFFFFF85; 10 -> 0x00008A85; 11 -> 0xFFFF8A85.
  - Data 0x7F7F mode 01 -> 0x0000007F.
- Round robin with resp_ready_i held 1:
  - Stimulus: all 4 requesters valid continuously.
  - Required: grant order 0,1,2,3,0,1; one result per cycle; done_cnt_o increases by 1 every cycle.
- Backpressure:
  - Stimulus: resp_ready_i=0 for 5 cycles with requests 1 and 3 pending.
  - Required: resp_data_o/resp_id_o stable, req_ready_o=0 throughout.
  - On release: grant goes to requester 3 then 1 if the last grant was 2.
- Reset mid-operation:
  - Stimulus: FULL with resp_ready_i=0, assert areset_i between clock edges.
  - Required: resp_valid_o drops immediately (asynchronously); done_cnt_o=0; first post-reset grant goes to the lowest valid index.
- Counter wrap:
  - Force 65536 completions.
  - Required: done_cnt_o returns to 0x0000; check with an assertion that samples values with $sampled() in its message.
